cmd_cfg_gen: RTL and testbench



---
 rtl/cmd_cfg_gen.sv | 216 +++++++++++++++++++++
 tb/tb_cmd_cfg_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_cfg_gen.sv
// Host command processor: 8-bit config register file, circular capture-RAM dumps, ACK/NAK.
// Optional dump checksum byte is enabled by defining CMD_CFG_GEN_CHKSUM_EN.
module cmd_cfg_gen #(
    parameter int NUM_CH    = 5,
    parameter int ENTRIES   = 384,
    parameter int LOG2      = 9,
    parameter int REG_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            cmd_i,
    input  logic                   cmd_rdy_i,
    input  logic                   resp_sent_i,
    input  logic                   set_capture_done_i,
    input  logic [LOG2-1:0]        ram_addr_i,
    input  logic [NUM_CH*8-1:0]    rdata_i,
    output logic [LOG2-1:0]        raddr_o,
    output logic [REG_DEPTH*8-1:0] regs_o,
    output logic [7:0]             resp_o,
    output logic                   send_resp_o,
    output logic                   clr_cmd_rdy_o
);

    localparam int         CW  = LOG2 + 1;
    localparam int         RW  = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, REG_RESP, WAIT_SENT, DUMP_RD, DUMP_SEND, DUMP_WAIT, DONE
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cmd_q, cmd_d;
    logic [LOG2-1:0] raddr_q, raddr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   len_q, len_d;
    logic [2:0]      ch_q, ch_d;
    logic [7:0]      resp_q, resp_d;
    logic            send_q, send_d;
    logic            clr_q, clr_d;
    logic [7:0]      regs_q [REG_DEPTH];
    logic [7:0]      regs_d [REG_DEPTH];
`ifdef CMD_CFG_GEN_CHKSUM_EN
    logic [7:0]      sum_q, sum_d;
    logic            chk_sent_q, chk_sent_d;
`endif

    logic [1:0]    op_in;
    logic          addr_ok_in, addr_ok_q, ch_ok_in;
    logic [RW-1:0] idx_in, idx_q;
    logic [7:0]    sel_byte;
    int            len_int;

    assign op_in      = cmd_i[15:14];
    assign idx_in     = cmd_i[8 +: RW];
    assign idx_q      = cmd_q[8 +: RW];
    assign addr_ok_in = int'(cmd_i[13:8]) < REG_DEPTH;
    assign addr_ok_q  = int'(cmd_q[13:8]) < REG_DEPTH;
    assign ch_ok_in   = (cmd_i[10:8] != 3'd0) && (int'(cmd_i[10:8]) <= NUM_CH);
    assign len_int    = (cmd_i[7:0] == 8'd0 || int'(cmd_i[7:0]) > ENTRIES)
                        ? ENTRIES : int'(cmd_i[7:0]);

    // Channel numbers are 1-based on the command interface, 0-based on rdata_i.
    always_comb begin
        sel_byte = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ch_q) == c + 1) sel_byte = rdata_i[8*c +: 8];
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before the case, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        cmd_d   = cmd_q;
        raddr_d = raddr_q;
        count_d = count_q;
        len_d   = len_q;
        ch_d    = ch_q;
        resp_d  = resp_q;
        send_d  = 1'b0;
        clr_d   = 1'b0;
        regs_d  = regs_q;
`ifdef CMD_CFG_GEN_CHKSUM_EN
        sum_d      = sum_q;
        chk_sent_d = chk_sent_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_rdy_i) begin
                    cmd_d = cmd_i;
                    if (op_in == OP_DUMP && ch_ok_in) begin
                        state_d = DUMP_RD;
                        raddr_d = ram_addr_i;
                        count_d = '0;
                        len_d   = CW'(len_int);
                        ch_d    = cmd_i[10:8];
`ifdef CMD_CFG_GEN_CHKSUM_EN
                        sum_d      = '0;
                        chk_sent_d = 1'b0;
`endif
                    end else begin
                        // Response and handshake pulses are registered so they appear during REG_RESP.
                        state_d = REG_RESP;
                        send_d  = 1'b1;
                        clr_d   = 1'b1;
                        case (op_in)
                            OP_READ:  resp_d = addr_ok_in ? regs_q[idx_in] : NAK;
                            OP_WRITE: resp_d = addr_ok_in ? ACK : NAK;
                            default:  resp_d = NAK;
                        endcase
                    end
                end
            end
            REG_RESP: begin
                if (cmd_q[15:14] == OP_WRITE && addr_ok_q) regs_d[idx_q] = cmd_q[7:0];
                state_d = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (resp_sent_i) state_d = IDLE;
            end
            DUMP_RD: begin
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                resp_d  = sel_byte;
                send_d  = 1'b1;
                raddr_d = (raddr_q == LOG2'(ENTRIES - 1)) ? '0 : raddr_q + 1'b1;
                count_d = count_q + 1'b1;
`ifdef CMD_CFG_GEN_CHKSUM_EN
                sum_d   = sum_q + sel_byte;
`endif
                state_d = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (resp_sent_i) begin
                    if (count_q == len_q) begin
`ifdef CMD_CFG_GEN_CHKSUM_EN
                        if (!chk_sent_q) begin
                            resp_d     = sum_q;
                            send_d     = 1'b1;
                            chk_sent_d = 1'b1;
                        end else begin
                            state_d = DONE;
                            clr_d   = 1'b1;
                        end
`else
                        state_d = DONE;
                        clr_d   = 1'b1;
`endif
                    end else begin
                        state_d = DUMP_RD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Applied after any register write so capture-done wins on reg0 bit 5.
        if (set_capture_done_i) regs_d[0][5] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            raddr_q <= '0;
            count_q <= '0;
            len_q   <= '0;
            ch_q    <= '0;
            resp_q  <= '0;
            send_q  <= 1'b0;
            clr_q   <= 1'b0;
            // NOTE: the register file is host-visible config, so it is reset like any other flop rather than left as uninitialised RAM.
            for (int r = 0; r < REG_DEPTH; r++) regs_q[r] <= '0;
`ifdef CMD_CFG_GEN_CHKSUM_EN
            sum_q      <= '0;
            chk_sent_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            raddr_q <= raddr_d;
            count_q <= count_d;
            len_q   <= len_d;
            ch_q    <= ch_d;
            resp_q  <= resp_d;
            send_q  <= send_d;
            clr_q   <= clr_d;
            regs_q  <= regs_d;
`ifdef CMD_CFG_GEN_CHKSUM_EN
            sum_q      <= sum_d;
            chk_sent_q <= chk_sent_d;
`endif
        end
    end

    for (genvar r = 0; r < REG_DEPTH; r++) begin : g_regs_out
        assign regs_o[8*r +: 8] = regs_q[r];
    end

    assign raddr_o       = raddr_q;
    assign resp_o        = resp_q;
    assign send_resp_o   = send_q;
    assign clr_cmd_rdy_o = clr_q;

endmodule

// File: tb/tb_cmd_cfg_gen.sv
// Scoreboard bench for cmd_cfg_gen: expected bytes are queued from a reference model, a monitor compares them.
module tb_cmd_cfg_gen;

    localparam int NUM_CH    = 5;
    localparam int ENTRIES   = 384;
    localparam int LOG2      = 9;
    localparam int REG_DEPTH = 32;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [15:0]            cmd_i = '0;
    logic                   cmd_rdy_i = 1'b0;
    logic                   resp_sent_i = 1'b0;
    logic                   set_capture_done_i = 1'b0;
    logic [LOG2-1:0]        ram_addr_i = '0;
    logic [NUM_CH*8-1:0]    rdata_i = '0;
    logic [LOG2-1:0]        raddr_o;
    logic [REG_DEPTH*8-1:0] regs_o;
    logic [7:0]             resp_o;
    logic                   send_resp_o;
    logic                   clr_cmd_rdy_o;

    cmd_cfg_gen #(
        .NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2), .REG_DEPTH(REG_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_i(cmd_i), .cmd_rdy_i(cmd_rdy_i),
        .resp_sent_i(resp_sent_i), .set_capture_done_i(set_capture_done_i),
        .ram_addr_i(ram_addr_i), .rdata_i(rdata_i), .raddr_o(raddr_o),
        .regs_o(regs_o), .resp_o(resp_o), .send_resp_o(send_resp_o),
        .clr_cmd_rdy_o(clr_cmd_rdy_o)
    );

    always #5 clk = ~clk;

    logic [7:0] mem   [NUM_CH][ENTRIES];
    logic [7:0] model [REG_DEPTH];
    logic [7:0] sb [$];
    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int resp_cnt = 0;

    // Capture RAM: one-cycle registered read on the shared address.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            rdata_i[8*c +: 8] <= (int'(raddr_o) < ENTRIES) ? mem[c][raddr_o] : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor plus host transmitter: pops expected bytes and answers each send with a delayed resp_sent.
    initial begin
        bit outstanding;
        int delay;
        outstanding = 1'b0;
        delay = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 1'b0;
                resp_sent_i = 1'b0;
            end else begin
                resp_sent_i = 1'b0;
                if (send_resp_o) begin
                    check("no_resend", 32'(outstanding), 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got %0h expected none", resp_o);
                    end else begin
                        check("resp", resp_o, sb.pop_front());
                    end
                    resp_cnt++;
                    outstanding = 1'b1;
                    delay = $urandom_range(1, 3);
                end else if (outstanding) begin
                    delay--;
                    if (delay == 0) begin
                        resp_sent_i = 1'b1;
                        outstanding = 1'b0;
                    end
                end
                if (clr_cmd_rdy_o) begin
                    clr_cnt++;
                    check("clr_after_last", sb.size(), 0);
                end
            end
        end
    end

    function automatic logic [REG_DEPTH*8-1:0] model_flat();
        logic [REG_DEPTH*8-1:0] f;
        for (int r = 0; r < REG_DEPTH; r++) f[8*r +: 8] = model[r];
        return f;
    endfunction

    task automatic expect_cmd(input logic [15:0] c, input bit cap);
        int a, ch, len;
        logic [7:0] d, b, sum;
        a  = int'(c[13:8]);
        ch = int'(c[10:8]);
        d  = c[7:0];
        case (c[15:14])
            2'b00: sb.push_back(a < REG_DEPTH ? model[a] : NAK);
            2'b01: begin
                if (a < REG_DEPTH) begin
                    sb.push_back(ACK);
                    model[a] = d;
                end else begin
                    sb.push_back(NAK);
                end
            end
            2'b10: begin
                if (ch >= 1 && ch <= NUM_CH) begin
                    len = (d == 0 || int'(d) > ENTRIES) ? ENTRIES : int'(d);
                    sum = '0;
                    for (int i = 0; i < len; i++) begin
                        b = mem[ch-1][(int'(ram_addr_i) + i) % ENTRIES];
                        sb.push_back(b);
                        sum = sum + b;
                    end
`ifdef CMD_CFG_GEN_CHKSUM_EN
                    sb.push_back(sum);
`endif
                end else begin
                    sb.push_back(NAK);
                end
            end
            default: sb.push_back(NAK);
        endcase
        if (cap) model[0][5] = 1'b1;
    endtask

    task automatic run_cmd(input logic [15:0] c, input bit cap, input bit chk_lat);
        int start_clr, cyc;
        start_clr = clr_cnt;
        expect_cmd(c, cap);
        @(negedge clk);
        cmd_i = c;
        cmd_rdy_i = 1'b1;
        set_capture_done_i = cap;
        @(negedge clk);
        if (chk_lat) check("latency", 32'(send_resp_o), 1);
        ram_addr_i = LOG2'($urandom_range(0, ENTRIES - 1));
        cyc = 0;
        while (!clr_cmd_rdy_o && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("clr_seen", 32'(clr_cmd_rdy_o), 1);
        cmd_rdy_i = 1'b0;
        @(negedge clk);
        set_capture_done_i = 1'b0;
        repeat (6) @(negedge clk);
        check("clr_count", 32'(clr_cnt - start_clr), 1);
        check("sb_empty", sb.size(), 0);
        check("regs", 32'(regs_o == model_flat()), 1);
    endtask

    initial begin
        int base, cyc;
        logic [5:0]  ra;
        logic [1:0]  op;
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < ENTRIES; i++) mem[c][i] = 8'($urandom);
        for (int i = 0; i < ENTRIES; i++) mem[0][i] = 8'(i);
        for (int r = 0; r < REG_DEPTH; r++) model[r] = '0;

        repeat (3) @(negedge clk);
        check("rst_resp", resp_o, 0);
        check("rst_send", 32'(send_resp_o), 0);
        check("rst_clr", 32'(clr_cmd_rdy_o), 0);
        check("rst_raddr", 32'(raddr_o), 0);
        check("rst_regs", 32'(regs_o == '0), 1);
        rst_n = 1'b1;

        run_cmd(16'h4B55, 1'b0, 1'b1);
        check("reg11", regs_o[8*11 +: 8], 8'h55);
        run_cmd(16'h0B55, 1'b0, 1'b1);
        run_cmd(16'hC000, 1'b0, 1'b1);
        run_cmd(16'h8600, 1'b0, 1'b1);
        run_cmd(16'h6012, 1'b0, 1'b1);
        run_cmd(16'h4000, 1'b1, 1'b1);
        check("reg0_capdone", regs_o[7:0], 8'h20);
        run_cmd(16'h0000, 1'b0, 1'b1);

        ram_addr_i = LOG2'(380);
        run_cmd(16'h8100, 1'b0, 1'b0);
        ram_addr_i = LOG2'(10);
        run_cmd(16'h8304, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10) op = 2'b01;
            ra = 6'($urandom_range(0, 40));
            run_cmd({op, ra, 8'($urandom)}, 1'b0, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            ram_addr_i = LOG2'($urandom_range(0, ENTRIES - 1));
            if (k == 0)
                run_cmd({2'b10, 3'b000, 3'd2, 8'h00}, 1'b0, 1'b0);
            else
                run_cmd({2'b10, 3'b000, 3'($urandom_range(0, 7)), 8'($urandom_range(1, 40))},
                        1'b0, 1'b0);
        end

        // Reset in the middle of a long dump.
        ram_addr_i = '0;
        expect_cmd(16'h8100, 1'b0);
        base = resp_cnt;
        @(negedge clk);
        cmd_i = 16'h8100;
        cmd_rdy_i = 1'b1;
        cyc = 0;
        while (resp_cnt < base + 50 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("dump_progress", 32'(resp_cnt >= base + 50), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_resp", resp_o, 0);
        check("mid_rst_send", 32'(send_resp_o), 0);
        check("mid_rst_clr", 32'(clr_cmd_rdy_o), 0);
        check("mid_rst_raddr", 32'(raddr_o), 0);
        check("mid_rst_regs", 32'(regs_o == '0), 1);
        cmd_rdy_i = 1'b0;
        sb.delete();
        for (int r = 0; r < REG_DEPTH; r++) model[r] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(16'h0000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
